// File: rtl/datapath_sequencer_if.sv
// Bus between the micro-sequencer and its controller.
// Carries the program load port, run control, and the datapath control fields.
interface datapath_sequencer_if;
  logic        Start;
  logic        Abort;
  logic        LoadEn;
  logic [3:0]  LoadAddr;
  logic [39:0] LoadData;
  logic        Busy;
  logic        Done;
  logic [3:0]  PC;
  logic [3:0]  SelectA;
  logic [3:0]  SelectB;
  logic [3:0]  SelectIn;
  logic [15:0] Immediate;
  logic [7:0]  OpCode;
  logic [1:0]  MuxSelect;
  logic        WriteEnable;

  modport master (
    output Start, Abort, LoadEn, LoadAddr, LoadData,
    input  Busy, Done, PC, SelectA, SelectB, SelectIn,
    input  Immediate, OpCode, MuxSelect, WriteEnable
  );

  modport slave (
    input  Start, Abort, LoadEn, LoadAddr, LoadData,
    output Busy, Done, PC, SelectA, SelectB, SelectIn,
    output Immediate, OpCode, MuxSelect, WriteEnable
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Programmable micro-sequencer: steps a 16-word control program, holding each
// word for TICK_DIV clocks and strobing WriteEnable on the last cycle of a step.
module datapath_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int TICK_DIV   = 30000000
) (
  input logic Clock,
  input logic Reset,
  datapath_sequencer_if.slave bus
);
  localparam logic [31:0] LastTick = 32'(TICK_DIV - 1);
  localparam logic [3:0]  LastPc   = 4'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  seqState_t   state;
  seqState_t   stateNext;
  logic [39:0] progMem [PROG_DEPTH];
  logic [31:0] tickCount;
  logic [3:0]  pcReg;
  logic [3:0]  pcNext;
  logic [39:0] curWord;
  logic        stepEnd;
  logic        lastStep;
  logic        loadAccept;
  logic        startAccept;
  logic        busyComb;
  logic        doneComb;
  logic        weComb;

  assign pcNext      = pcReg + 4'd1;
  assign stepEnd     = (state == RUN) && (tickCount == LastTick);
  assign lastStep    = curWord[39] || (pcReg == LastPc);
  assign loadAccept  = (state == IDLE) && bus.LoadEn;
  assign startAccept = (state == IDLE) && bus.Start && !bus.LoadEn;

  // Program store survives Reset so a reset mid-run can simply rerun it.
  always_ff @(posedge Clock) begin
    if (loadAccept) begin
      progMem[bus.LoadAddr] <= bus.LoadData;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    busyComb  = 1'b0;
    doneComb  = 1'b0;
    weComb    = 1'b0;
    case (state)
      IDLE: begin
        if (startAccept) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        busyComb = 1'b1;
        // Abort takes priority and swallows a commit landing in the same cycle.
        if (bus.Abort) begin
          stateNext = IDLE;
        end else begin
          weComb = stepEnd && curWord[36];
          if (stepEnd && lastStep) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        doneComb  = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Step registers: the next word is fetched on the same edge that closes a
  // step, so consecutive steps run back to back.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tickCount <= '0;
      pcReg     <= '0;
      curWord   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tickCount <= '0;
          pcReg     <= '0;
          curWord   <= startAccept ? progMem[4'd0] : '0;
        end
        RUN: begin
          if (bus.Abort) begin
            tickCount <= '0;
            pcReg     <= '0;
            curWord   <= '0;
          end else if (stepEnd) begin
            tickCount <= '0;
            if (!lastStep) begin
              pcReg   <= pcNext;
              curWord <= progMem[pcNext];
            end
          end else begin
            tickCount <= tickCount + 32'd1;
          end
        end
        default: begin
          tickCount <= '0;
          pcReg     <= '0;
          curWord   <= '0;
        end
      endcase
    end
  end

  assign bus.Busy        = busyComb;
  assign bus.Done        = doneComb;
  assign bus.WriteEnable = weComb;
  assign bus.PC          = pcReg;
  assign bus.MuxSelect   = curWord[38:37];
  assign bus.OpCode      = curWord[35:28];
  assign bus.SelectIn    = curWord[27:24];
  assign bus.SelectA     = curWord[23:20];
  assign bus.SelectB     = curWord[19:16];
  assign bus.Immediate   = curWord[15:0];
endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a step/phase reference model.
module tb_datapath_sequencer;
  localparam int TD = 4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  datapath_sequencer_if sif ();

  datapath_sequencer #(
    .PROG_DEPTH(16),
    .TICK_DIV  (TD)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (sif)
  );

  int nChecks = 0;
  int nBad    = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: phase = cycles since the accepted Start edge (0 = idle).
  logic [39:0] refProg [16];
  int phase      = 0;
  int stepsInRun = 0;
  int cyc        = 0;
  int startEdge  = 0;
  int doneRel    = -1;
  int strobeRel[$];
  int strobeSel[$];
  int strobePc[$];

  function automatic int programLength();
    for (int k = 0; k < 16; k++) begin
      if (refProg[k][39] === 1'b1 || k == 15) return k + 1;
    end
    return 16;
  endfunction

  function automatic logic [37:0] fieldsOf(input logic [39:0] w);
    return {w[23:20], w[19:16], w[27:24], w[15:0], w[35:28], w[38:37]};
  endfunction

  function automatic logic [44:0] observed();
    return {sif.Busy, sif.Done, sif.PC, sif.SelectA, sif.SelectB, sif.SelectIn,
            sif.Immediate, sif.OpCode, sif.MuxSelect, sif.WriteEnable};
  endfunction

  function automatic logic [44:0] expectedOutputs();
    int step;
    logic [39:0] w;
    logic we;
    if (Reset !== 1'b1 || phase == 0) return '0;
    if (phase <= stepsInRun * TD) begin
      step = (phase - 1) / TD;
      w    = refProg[step];
      we   = ((phase % TD) == 0) && w[36] && !sif.Abort;
      return {1'b1, 1'b0, 4'(step), fieldsOf(w), we};
    end
    w = refProg[stepsInRun - 1];
    return {1'b0, 1'b1, 4'(stepsInRun - 1), fieldsOf(w), 1'b0};
  endfunction

  task automatic modelStep();
    if (Reset !== 1'b1) begin
      phase = 0;
    end else if (phase == 0) begin
      if (sif.LoadEn) begin
        refProg[sif.LoadAddr] = sif.LoadData;
      end else if (sif.Start) begin
        phase      = 1;
        stepsInRun = programLength();
      end
    end else if (phase <= stepsInRun * TD) begin
      phase = sif.Abort ? 0 : phase + 1;
    end else begin
      phase = 0;
    end
  endtask

  task automatic runCycle();
    @(negedge Clock);
    checkEq("outputs", 64'(observed()), 64'(expectedOutputs()));
    if (sif.WriteEnable === 1'b1) begin
      strobeRel.push_back(cyc + 1 - startEdge);
      strobeSel.push_back(int'(sif.SelectIn));
      strobePc.push_back(int'(sif.PC));
    end
    if (sif.Done === 1'b1) doneRel = cyc + 1 - startEdge;
    @(posedge Clock);
    cyc++;
    modelStep();
    #1;
  endtask

  task automatic runFor(input int n);
    repeat (n) runCycle();
  endtask

  task automatic clearInputs();
    sif.Start    = 1'b0;
    sif.Abort    = 1'b0;
    sif.LoadEn   = 1'b0;
    sif.LoadAddr = '0;
    sif.LoadData = '0;
  endtask

  task automatic loadWord(input logic [3:0] a, input logic [39:0] d);
    sif.LoadEn   = 1'b1;
    sif.LoadAddr = a;
    sif.LoadData = d;
    runCycle();
    clearInputs();
  endtask

  task automatic startRun();
    strobeRel.delete();
    strobeSel.delete();
    strobePc.delete();
    doneRel   = -1;
    startEdge = cyc + 1;
    sif.Start = 1'b1;
    runCycle();
    sif.Start = 1'b0;
  endtask

  function automatic int qAt(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [39:0] mkWord(input logic last, input logic [1:0] mux,
      input logic we, input logic [7:0] op, input logic [3:0] sIn,
      input logic [3:0] sA, input logic [3:0] sB, input logic [15:0] imm);
    return {last, mux, we, op, sIn, sA, sB, imm};
  endfunction

  logic [39:0] addW0, addW1, addW2, altW0;
  logic [63:0] rnd;

  initial begin
    addW0 = mkWord(1'b0, 2'd1, 1'b1, 8'h06, 4'd2, 4'd0, 4'd1, 16'h0000);
    addW1 = mkWord(1'b0, 2'd1, 1'b1, 8'h06, 4'd3, 4'd1, 4'd2, 16'h0000);
    addW2 = mkWord(1'b1, 2'd1, 1'b1, 8'h06, 4'd4, 4'd2, 4'd3, 16'h0000);
    altW0 = mkWord(1'b1, 2'd2, 1'b1, 8'hAA, 4'd9, 4'd7, 4'd8, 16'hBEEF);
    Reset = 1'b0;
    clearInputs();
    runFor(2);
    checkEq("reset_outputs", 64'(observed()), 64'd0);
    Reset = 1'b1;
    runFor(2);

    // Full 16-word program without Last: runs to the end of the store.
    for (int k = 0; k < 16; k++) begin
      loadWord(4'(k), mkWord(1'b0, 2'($urandom_range(0, 3)), 1'b1, 8'($urandom),
                             4'(k), 4'($urandom), 4'($urandom), 16'($urandom)));
    end
    startRun();
    runFor(16 * TD + 2);
    checkEq("full_strobes", 64'(strobeRel.size()), 64'd16);
    checkEq("full_last_pc", 64'(qAt(strobePc, 15)), 64'd15);
    checkEq("full_last_sel", 64'(qAt(strobeSel, 15)), 64'd15);
    checkEq("full_done", 64'(doneRel), 64'(16 * TD + 1));

    // Three-instruction add chain.
    loadWord(4'd0, addW0);
    loadWord(4'd1, addW1);
    loadWord(4'd2, addW2);
    startRun();
    runFor(14);
    checkEq("add_strobes", 64'(strobeRel.size()), 64'd3);
    checkEq("add_rel0", 64'(qAt(strobeRel, 0)), 64'd4);
    checkEq("add_rel1", 64'(qAt(strobeRel, 1)), 64'd8);
    checkEq("add_rel2", 64'(qAt(strobeRel, 2)), 64'd12);
    checkEq("add_sel0", 64'(qAt(strobeSel, 0)), 64'd2);
    checkEq("add_sel1", 64'(qAt(strobeSel, 1)), 64'd3);
    checkEq("add_sel2", 64'(qAt(strobeSel, 2)), 64'd4);
    checkEq("add_done", 64'(doneRel), 64'd13);

    // Single terminal step without a commit.
    loadWord(4'd0, mkWord(1'b1, 2'd0, 1'b0, 8'h11, 4'd5, 4'd1, 4'd1, 16'h1234));
    startRun();
    runFor(TD + 3);
    checkEq("nowe_strobes", 64'(strobeRel.size()), 64'd0);
    checkEq("nowe_done", 64'(doneRel), 64'(TD + 1));

    // Abort on the commit cycle of step 1.
    loadWord(4'd0, addW0);
    startRun();
    runFor(2 * TD - 1);
    sif.Abort = 1'b1;
    runCycle();
    sif.Abort = 1'b0;
    checkEq("abort_strobes", 64'(strobeRel.size()), 64'd1);
    checkEq("abort_idle", 64'(observed()), 64'd0);
    runFor(3);
    checkEq("abort_no_done", 64'(doneRel), 64'hFFFF_FFFF_FFFF_FFFF);
    startRun();
    runFor(14);
    checkEq("rerun_strobes", 64'(strobeRel.size()), 64'd3);
    checkEq("rerun_rel0", 64'(qAt(strobeRel, 0)), 64'd4);

    // Start and load during RUN are both ignored.
    startRun();
    runFor(2);
    sif.Start    = 1'b1;
    sif.LoadEn   = 1'b1;
    sif.LoadAddr = 4'd0;
    sif.LoadData = altW0;
    runCycle();
    clearInputs();
    runFor(12);
    checkEq("busy_load_done", 64'(doneRel), 64'd13);
    checkEq("busy_load_strobes", 64'(strobeRel.size()), 64'd3);
    startRun();
    runFor(14);
    checkEq("old_entry0_sel", 64'(qAt(strobeSel, 0)), 64'd2);

    // Load together with Start in IDLE: load wins, no run.
    sif.Start    = 1'b1;
    sif.LoadEn   = 1'b1;
    sif.LoadAddr = 4'd0;
    sif.LoadData = altW0;
    runCycle();
    clearInputs();
    checkEq("load_start_idle", 64'(sif.Busy), 64'd0);
    runCycle();
    startRun();
    runFor(TD + 2);
    checkEq("new_entry0_sel", 64'(qAt(strobeSel, 0)), 64'd9);
    checkEq("new_entry0_done", 64'(doneRel), 64'(TD + 1));

    // Asynchronous reset in the middle of step 2.
    loadWord(4'd0, addW0);
    startRun();
    runFor(9);
    #2;
    Reset = 1'b0;
    phase = 0;
    #1;
    checkEq("async_reset", 64'(observed()), 64'd0);
    runCycle();
    Reset = 1'b1;
    runCycle();
    startRun();
    runFor(14);
    checkEq("post_reset_strobes", 64'(strobeRel.size()), 64'd3);
    checkEq("post_reset_rel2", 64'(qAt(strobeRel, 2)), 64'd12);
    checkEq("post_reset_sel2", 64'(qAt(strobeSel, 2)), 64'd4);
    checkEq("post_reset_done", 64'(doneRel), 64'd13);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rnd          = {$urandom, $urandom};
      sif.Start    = ($urandom_range(0, 7) == 0);
      sif.Abort    = ($urandom_range(0, 39) == 0);
      sif.LoadEn   = ($urandom_range(0, 9) == 0);
      sif.LoadAddr = 4'($urandom_range(0, 15));
      sif.LoadData = {($urandom_range(0, 3) == 0), rnd[38:0]};
      runCycle();
    end
    clearInputs();
    runFor(4);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
